ysyx_24100005_ifu: RTL and testbench

YSYX_24100005_IFU -- requirements
Module: ysyx_24100005_ifu

---
 rtl/ysyx_24100005_ifu.sv | 122 ++++++++++++
 tb/tb_ysyx_24100005_ifu.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: one outstanding fetch at a time, with redirect handling.
// A kill flag marks a response that belongs to a stale fetch address, so it can be discarded.
module ysyx_24100005_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [31:0] rsp_data,
    input  logic        rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_err,
    output logic        inst_misal,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic        kill, kill_next;
    logic [31:0] buf_inst, buf_inst_next;
    logic        buf_err, buf_err_next;
    logic        buf_misal, buf_misal_next;
    logic        aligned;

    assign aligned    = (pc[1:0] == 2'b00);
    assign req_valid  = (state == REQ) && aligned;
    assign req_addr   = pc;
    assign rsp_ready  = (state == WAIT);
    assign inst_valid = (state == OUT) && !redirect_valid;
    assign inst       = buf_inst;
    assign inst_err   = buf_err;
    assign inst_misal = buf_misal;
    assign inst_pc    = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            kill      <= 1'b0;
            buf_inst  <= 32'h0;
            buf_err   <= 1'b0;
            buf_misal <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            kill      <= kill_next;
            buf_inst  <= buf_inst_next;
            buf_err   <= buf_err_next;
            buf_misal <= buf_misal_next;
        end
    end

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        kill_next      = kill;
        buf_inst_next  = buf_inst;
        buf_err_next   = buf_err;
        buf_misal_next = buf_misal;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (redirect_valid) begin
                    // A request accepted this cycle still carries the old address.
                    pc_next = redirect_pc;
                    if (req_valid && req_ready) begin
                        state_next = WAIT;
                        kill_next  = 1'b1;
                    end
                end else if (!aligned) begin
                    buf_inst_next  = 32'h0;
                    buf_err_next   = 1'b0;
                    buf_misal_next = 1'b1;
                    state_next     = OUT;
                end else if (req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (rsp_valid) begin
                    if (redirect_valid) begin
                        pc_next    = redirect_pc;
                        kill_next  = 1'b0;
                        state_next = REQ;
                    end else if (kill) begin
                        kill_next  = 1'b0;
                        state_next = REQ;
                    end else begin
                        buf_inst_next  = rsp_data;
                        buf_err_next   = rsp_err;
                        buf_misal_next = 1'b0;
                        state_next     = OUT;
                    end
                end else if (redirect_valid) begin
                    pc_next   = redirect_pc;
                    kill_next = 1'b1;
                end
            end
            OUT: begin
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    state_next = REQ;
                end else if (inst_ready) begin
                    pc_next    = pc + 32'd4;
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Cycle-by-cycle directed vectors for the fetch unit, plus reset corner sequences.
module tb_ysyx_24100005_ifu;

    localparam logic [31:0] B = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic        inst_err, inst_misal;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int passed = 0;
    int total  = 0;

    ysyx_24100005_ifu #(.RESET_PC(B)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .inst_err(inst_err), .inst_misal(inst_misal),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rq_rdy, rsp_v;
        logic [31:0] rsp_d;
        logic        rsp_e, i_rdy, rd_v;
        logic [31:0] rd_pc;
        logic        e_rv, e_rr, e_iv;
        logic [31:0] e_addr, e_inst, e_pc;
        logic        e_err, e_misal;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rq_rdy, input logic rsp_v, input logic [31:0] rsp_d,
                       input logic rsp_e, input logic i_rdy, input logic rd_v,
                       input logic [31:0] rd_pc, input logic e_rv, input logic e_rr,
                       input logic e_iv, input logic [31:0] e_addr, input logic [31:0] e_inst,
                       input logic [31:0] e_pc, input logic e_err, input logic e_misal);
        vec_t v;
        v.rq_rdy = rq_rdy; v.rsp_v = rsp_v; v.rsp_d = rsp_d; v.rsp_e = rsp_e;
        v.i_rdy = i_rdy; v.rd_v = rd_v; v.rd_pc = rd_pc;
        v.e_rv = e_rv; v.e_rr = e_rr; v.e_iv = e_iv; v.e_addr = e_addr;
        v.e_inst = e_inst; v.e_pc = e_pc; v.e_err = e_err; v.e_misal = e_misal;
        vecs.push_back(v);
    endtask

    // Addresses and instruction fields only matter while their valid is high.
    function automatic logic [100:0] bundle(input logic rv, input logic rr, input logic iv,
                                            input logic [31:0] addr, input logic [31:0] ins,
                                            input logic err, input logic mis,
                                            input logic [31:0] pc);
        return {rv, rr, iv, rv ? addr : 32'h0, iv ? ins : 32'h0,
                iv ? err : 1'b0, iv ? mis : 1'b0, iv ? pc : 32'h0};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic rq, input logic rv, input logic [31:0] rd, input logic re,
                         input logic ir, input logic dv, input logic [31:0] dpc);
        req_ready = rq; rsp_valid = rv; rsp_data = rd; rsp_err = re;
        inst_ready = ir; redirect_valid = dv; redirect_pc = dpc;
    endtask

    function automatic logic [127:0] reset_view();
        return {59'h0, req_valid, rsp_ready, inst_valid, inst, inst_err, inst_misal, inst_pc};
    endfunction

    function automatic logic [127:0] reset_exp();
        return {59'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, B};
    endfunction

    initial begin
        // rq rv data err ir rdv rdpc | erv err eiv addr inst pc err mis
        add(1, 0, 0, 0, 1, 0, 0,                    0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0,                    1, 0, 0, B, 0, 0, 0, 0);
        add(0, 1, 32'h13, 0, 1, 0, 0,               0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0,                    0, 0, 1, 0, 32'h13, B, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0,                    1, 0, 0, B + 4, 0, 0, 0, 0);
        add(0, 1, 32'h0010_0093, 0, 1, 0, 0,        0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0,                    0, 0, 1, 0, 32'h0010_0093, B + 4, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0,                    1, 0, 0, B + 8, 0, 0, 0, 0);
        add(0, 1, 32'h0, 1, 1, 0, 0,                0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            add(1, 0, 0, 0, 0, 0, 0,                0, 0, 1, 0, 0, B + 8, 1, 0);
        add(1, 0, 0, 0, 1, 0, 0,                    0, 0, 1, 0, 0, B + 8, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0,                    1, 0, 0, B + 12, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0,                    1, 0, 0, B + 12, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0,                    1, 0, 0, B + 12, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0,                    0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, B + 32'h100,          0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 32'hDEAD_BEEF, 0, 1, 0, 0,        0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0,                    1, 0, 0, B + 32'h100, 0, 0, 0, 0);
        add(0, 1, 32'h1111_1111, 0, 1, 0, 0,        0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0,                    0, 0, 1, 0, 32'h1111_1111, B + 32'h100, 0, 0);
        add(0, 0, 0, 0, 1, 1, B + 32'h200,          1, 0, 0, B + 32'h104, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, B + 32'h300,          1, 0, 0, B + 32'h200, 0, 0, 0, 0);
        add(0, 1, 32'h2222_2222, 0, 1, 0, 0,        0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0,                    1, 0, 0, B + 32'h300, 0, 0, 0, 0);
        add(0, 1, 32'h4444_4444, 0, 1, 1, B + 32'h102, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0,                    0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,                    0, 0, 1, 0, 0, B + 32'h102, 0, 1);
        add(0, 0, 0, 0, 1, 1, 32'hFFFF_FFFC,        0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0,                    1, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, 0);
        add(0, 1, 32'h3333_3333, 0, 1, 0, 0,        0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0,                    0, 0, 1, 0, 32'h3333_3333, 32'hFFFF_FFFC, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0,                    1, 0, 0, 32'h0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0,                    0, 1, 0, 0, 0, 0, 0, 0);

        drive(1, 1, 32'hFFFF_FFFF, 1, 1, 1, 32'h1234_5678);
        @(negedge clk);
        #1 check("reset_hold", reset_view(), reset_exp());
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].rq_rdy, vecs[i].rsp_v, vecs[i].rsp_d, vecs[i].rsp_e,
                  vecs[i].i_rdy, vecs[i].rd_v, vecs[i].rd_pc);
            #1 check($sformatf("vec%0d", i),
                     {27'h0, bundle(req_valid, rsp_ready, inst_valid, req_addr, inst,
                                    inst_err, inst_misal, inst_pc)},
                     {27'h0, bundle(vecs[i].e_rv, vecs[i].e_rr, vecs[i].e_iv, vecs[i].e_addr,
                                    vecs[i].e_inst, vecs[i].e_err, vecs[i].e_misal,
                                    vecs[i].e_pc)});
            @(posedge clk);
            @(negedge clk);
        end

        // Reset asserted while a fetch is outstanding must clear outputs without a clock edge.
        drive(0, 0, 0, 0, 1, 0, 0);
        #1 check("wait_before_rst", {127'h0, rsp_ready}, {127'h0, 1'b1});
        rst = 1'b1;
        #1 check("async_rst", reset_view(), reset_exp());
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1, 32'hBAD0_BAD0, 1, 1, 1, 32'h1234_5678);
        #1 check("idle_after_rst", {125'h0, req_valid, rsp_ready, inst_valid}, 128'h0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1, 32'hBAD0_BAD0, 1, 1, 0, 0);
        #1 check("late_rsp_req", {93'h0, req_valid, rsp_ready, inst_valid, req_addr},
                 {93'h0, 1'b1, 1'b0, 1'b0, B});
        @(posedge clk);
        @(negedge clk);
        #1 check("late_rsp_ignored", {93'h0, req_valid, rsp_ready, inst_valid, req_addr},
                 {93'h0, 1'b1, 1'b0, 1'b0, B});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
